// File: rtl/mem_copy_pkg.sv
// Shared types and helpers for the memory copy engine.
package mem_copy_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int unsigned DEF_AXI_WIDTH = 128;
    localparam int unsigned BYTES         = DEF_AXI_WIDTH / 8;
    localparam int unsigned LSB           = $clog2(DEF_AXI_WIDTH) - 3;
    localparam int unsigned MAX_BYTES     = 128;

    // Final-beat byte enables: the low (len mod nbytes) lanes, or every lane when the tail is zero.
    function automatic logic [MAX_BYTES-1:0] tail_strb(input logic [31:0] len,
                                                       input int unsigned nbytes);
        logic [31:0] tail;
        tail      = len & (nbytes - 1);
        tail_strb = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes) tail_strb[i] = (tail == '0) || (i < tail);
        end
    endfunction

endpackage

// File: rtl/mem_copy_wr_stage.sv
// One-beat register stage between the mm2s read return and the s2mm write port.
module mem_copy_wr_stage
    import mem_copy_pkg::*;
#(
    parameter  int AXI_WIDTH = 128,
    parameter  int AW        = 28,
    localparam int SBYTES    = AXI_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 valid,
    input  logic                 last,
    input  logic [SBYTES-1:0]    tail,
    input  logic [AW-1:0]        addr,
    input  logic [AXI_WIDTH-1:0] data,
    output logic                 wen,
    output logic                 wr_last,
    output logic [AW-1:0]        wr_addr,
    output logic [AXI_WIDTH-1:0] wr_data,
    output logic [SBYTES-1:0]    wr_strb
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wen     <= 1'b0;
            wr_last <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else begin
            wen     <= valid;
            wr_last <= valid && last;
            wr_addr <= valid ? addr : '0;
            wr_data <= valid ? data : '0;
            wr_strb <= valid ? (last ? tail : '1) : '0;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Word-addressed memory copy initiator: streams reads on mm2s and writes the data back on s2mm.
// Optional MEM_COPY_PERF_EN adds the perf_cycles busy-cycle counter port.
module mem_copy_engine #(
    parameter  int AXI_WIDTH      = 128,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int LEN_WIDTH      = 32,
    localparam int BYTES          = AXI_WIDTH / 8,
    localparam int LSB            = $clog2(AXI_WIDTH) - 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [AXI_ADDR_WIDTH-1:0]     src_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]     dst_addr,
    input  logic [LEN_WIDTH-1:0]          len_bytes,
    output logic                          busy,
    output logic                          done,
    output logic                          mm2s_ren,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] mm2s_addr,
    input  logic [AXI_WIDTH-1:0]          mm2s_data,
    output logic                          s2mm_wen,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] s2mm_addr,
    output logic [AXI_WIDTH-1:0]          s2mm_data,
    output logic [BYTES-1:0]              s2mm_strb
`ifdef MEM_COPY_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);
    import mem_copy_pkg::*;

    localparam int AW = AXI_ADDR_WIDTH - LSB;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   rd_left;
    logic [LEN_WIDTH-1:0]   beats;
    logic [AW-1:0]          wr_addr;
    logic [BYTES-1:0]       last_strb;
    logic [MAX_BYTES-1:0]   strb_full;
    logic                   rd_vld;
    logic                   rd_last;
    logic                   wr_last;

    always_comb begin
        beats     = (len_bytes >> LSB) + LEN_WIDTH'(len_bytes[LSB-1:0] != '0);
        strb_full = tail_strb(32'(len_bytes), BYTES);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mm2s_ren  <= 1'b0;
            mm2s_addr <= '0;
            rd_left   <= '0;
            wr_addr   <= '0;
            last_strb <= '0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            // rd_vld marks the cycle mm2s_data is valid; the write stage captures it at the next edge.
            rd_vld  <= mm2s_ren;
            rd_last <= mm2s_ren && (rd_left == '0);
            done    <= 1'b0;
            if (rd_vld) wr_addr <= wr_addr + AW'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        mm2s_addr <= src_addr[AXI_ADDR_WIDTH-1:LSB];
                        wr_addr   <= dst_addr[AXI_ADDR_WIDTH-1:LSB];
                        last_strb <= strb_full[BYTES-1:0];
                        if (len_bytes == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            mm2s_ren <= 1'b1;
                            rd_left  <= beats - LEN_WIDTH'(1);
                        end
                    end
                end
                RUN: begin
                    if (rd_left == '0) begin
                        mm2s_ren <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        mm2s_addr <= mm2s_addr + AW'(1);
                        rd_left   <= rd_left - LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (s2mm_wen && wr_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_copy_wr_stage #(
        .AXI_WIDTH (AXI_WIDTH),
        .AW        (AW)
    ) u_wr_stage (
        .clk     (clk),
        .rstn    (rstn),
        .valid   (rd_vld),
        .last    (rd_last),
        .tail    (last_strb),
        .addr    (wr_addr),
        .data    (mm2s_data),
        .wen     (s2mm_wen),
        .wr_last (wr_last),
        .wr_addr (s2mm_addr),
        .wr_data (s2mm_data),
        .wr_strb (s2mm_strb)
    );

`ifdef MEM_COPY_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles <= '0;
        end else if (state == IDLE) begin
            if (start) perf_cycles <= '0;
        end else if (perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a 1-cycle-latency RAM model; define MEM_COPY_PERF_EN to cover perf_cycles.
module tb_mem_copy_engine;

    localparam int AXI_WIDTH      = 128;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int LEN_WIDTH      = 32;
    localparam int AW             = 28;

    logic              clk       = 1'b0;
    logic              rstn      = 1'b0;
    logic              start     = 1'b0;
    logic [31:0]       src_addr  = '0;
    logic [31:0]       dst_addr  = '0;
    logic [31:0]       len_bytes = '0;
    logic              busy, done, mm2s_ren, s2mm_wen;
    logic [AW-1:0]     mm2s_addr, s2mm_addr;
    logic [127:0]      mm2s_data = '0;
    logic [127:0]      s2mm_data;
    logic [15:0]       s2mm_strb;
`ifdef MEM_COPY_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    always #5 clk = ~clk;

    mem_copy_engine #(
        .AXI_WIDTH      (AXI_WIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_bytes (len_bytes),
        .busy      (busy),
        .done      (done),
        .mm2s_ren  (mm2s_ren),
        .mm2s_addr (mm2s_addr),
        .mm2s_data (mm2s_data),
        .s2mm_wen  (s2mm_wen),
        .s2mm_addr (s2mm_addr),
        .s2mm_data (s2mm_data),
        .s2mm_strb (s2mm_strb)
`ifdef MEM_COPY_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic [15:0]   strb;
    } wr_t;

    logic [AW-1:0] rd_q [$];
    wr_t           wr_q [$];
    logic [127:0]  mem [int unsigned];
    int            errors   = 0;
    int            checks   = 0;
    int            wr_seen  = 0;
    int            done_cnt = 0;
    logic [AW-1:0] mon_rd;
    wr_t           mon_wr;
    logic [127:0]  ram_w;

    function automatic logic [127:0] pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w ^ 32'hA5A5_0000, w * 32'd3 + 32'd7, ~w, w + 32'h1234_5678};
    endfunction

    function automatic logic [127:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return pat(a);
    endfunction

    function automatic logic [15:0] exp_strb(input logic [31:0] l);
        int unsigned t;
        t = l % 16;
        if (t == 0) return 16'hFFFF;
        return 16'((32'd1 << t) - 32'd1);
    endfunction

    // RAM model: registered read data, byte-masked writes.
    always @(posedge clk) begin
        if (mm2s_ren) mm2s_data <= mem_rd(mm2s_addr);
        if (s2mm_wen) begin
            ram_w = mem_rd(s2mm_addr);
            for (int i = 0; i < 16; i++)
                if (s2mm_strb[i]) ram_w[i*8 +: 8] = s2mm_data[i*8 +: 8];
            mem[32'(s2mm_addr)] = ram_w;
        end
    end

    // Scoreboard: pop expected accesses as the DUT issues them.
    always @(negedge clk) begin
        if (rstn) begin
            if (mm2s_ren) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: got addr=%h, expected no read", mm2s_addr);
                end else begin
                    mon_rd = rd_q.pop_front();
                    if (mm2s_addr !== mon_rd) begin
                        errors++;
                        $display("FAIL read_addr: got %h, expected %h", mm2s_addr, mon_rd);
                    end
                end
            end
            checks++;
            if (s2mm_wen) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%h, expected no write", s2mm_addr);
                end else begin
                    mon_wr = wr_q.pop_front();
                    if (s2mm_addr !== mon_wr.addr || s2mm_data !== mon_wr.data || s2mm_strb !== mon_wr.strb) begin
                        errors++;
                        $display("FAIL write_beat: got addr=%h strb=%h data=%h, expected addr=%h strb=%h data=%h",
                                 s2mm_addr, s2mm_strb, s2mm_data, mon_wr.addr, mon_wr.strb, mon_wr.data);
                    end
                end
            end else if (s2mm_data !== '0 || s2mm_strb !== '0) begin
                errors++;
                $display("FAIL write_idle_zero: got data=%h strb=%h, expected 0", s2mm_data, s2mm_strb);
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        int unsigned   nb;
        logic [AW-1:0] sw, dw;
        nb = (l + 32'd15) / 32'd16;
        sw = s[31:4];
        dw = d[31:4];
        for (int unsigned k = 0; k < nb; k++) begin
            rd_q.push_back(sw + AW'(k));
            wr_q.push_back(wr_t'{dw + AW'(k), mem_rd(sw + AW'(k)), (k == nb - 1) ? exp_strb(l) : 16'hFFFF});
        end
    endtask

    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int restart_at, output int lat, output logic busy1);
        repeat (2) @(negedge clk);
        push_expect(s, d, l);
        start = 1'b1; src_addr = s; dst_addr = d; len_bytes = l;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        busy1 = busy;
        while (done !== 1'b1 && lat < 400) begin
            if (lat == restart_at) begin
                start = 1'b1; src_addr = 32'h5000; len_bytes = 32'd16;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", lat);
        end
    endtask

    task automatic check_copy(input string name, input logic [31:0] s, input logic [31:0] d, input int unsigned nb);
        for (int unsigned k = 0; k < nb; k++) begin
            checks++;
            if (mem_rd(d[31:4] + AW'(k)) !== pat(s[31:4] + AW'(k))) begin
                errors++;
                $display("FAIL %s_mem[%0d]: got %h, expected %h", name, k,
                         mem_rd(d[31:4] + AW'(k)), pat(s[31:4] + AW'(k)));
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mm2s_ren, s2mm_wen} !== 4'b0 || mm2s_addr !== '0 || s2mm_addr !== '0
            || s2mm_data !== '0 || s2mm_strb !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b ren=%b wen=%b, expected all 0",
                     busy, done, mm2s_ren, s2mm_wen);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat; logic b1; int w0;
        w0 = wr_seen;
        do_copy(32'h1000, 32'h2000, 32'd64, 0, lat, b1);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL basic_latency: got %0d, expected 7", lat); end
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, expected 1", b1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b, expected 0", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_seen - w0 != 4 || rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL basic_counts: got writes=%0d pending=%0d/%0d, expected 4 0/0", wr_seen - w0, rd_q.size(), wr_q.size());
        end
        check_copy("basic", 32'h1000, 32'h2000, 4);
    endtask

    task automatic test_tail();
        int lat; logic b1;
        logic [127:0] a, b, e;
        do_copy(32'h0, 32'h400, 32'd20, 0, lat, b1);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL tail_latency: got %0d, expected 5", lat); end
        repeat (3) @(negedge clk);
        check_copy("tail", 32'h0, 32'h400, 1);
        a = pat(28'h41);
        b = pat(28'h1);
        e = {a[127:32], b[31:0]};
        checks++;
        if (mem_rd(28'h41) !== e) begin
            errors++;
            $display("FAIL tail_partial_word: got %h, expected %h", mem_rd(28'h41), e);
        end
    endtask

    task automatic test_zero_len();
        int lat; logic b1; int w0, d0;
        w0 = wr_seen; d0 = done_cnt;
        do_copy(32'h1000, 32'h2400, 32'd0, 0, lat, b1);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d, expected 1", lat); end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_seen != w0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_counts: got writes=%0d dones=%0d, expected 0 1", wr_seen - w0, done_cnt - d0);
        end
    endtask

    task automatic test_restart_ignored();
        int lat; logic b1; int w0, d0;
        w0 = wr_seen; d0 = done_cnt;
        do_copy(32'h3000, 32'h8000, 32'd256, 3, lat, b1);
        checks++;
        if (lat != 19) begin errors++; $display("FAIL restart_latency: got %0d, expected 19", lat); end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_seen - w0 != 16 || done_cnt - d0 != 1 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL restart_counts: got writes=%0d dones=%0d, expected 16 1", wr_seen - w0, done_cnt - d0);
        end
        check_copy("restart", 32'h3000, 32'h8000, 16);
    endtask

    task automatic test_abort();
        int lat; logic b1; int d0;
        repeat (2) @(negedge clk);
        push_expect(32'h6000, 32'h7000, 32'd128);
        start = 1'b1; src_addr = 32'h6000; dst_addr = 32'h7000; len_bytes = 32'd128;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, mm2s_ren, s2mm_wen} !== 4'b0 || mm2s_addr !== '0 || s2mm_addr !== '0
            || s2mm_data !== '0 || s2mm_strb !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b ren=%b wen=%b strb=%h, expected all 0",
                     busy, done, mm2s_ren, s2mm_wen, s2mm_strb);
        end
        rd_q.delete();
        wr_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got dones=%0d busy=%b, expected 0 0", done_cnt - d0, busy);
        end
        do_copy(32'h6000, 32'h9000, 32'd48, 0, lat, b1);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL abort_fresh_latency: got %0d, expected 6", lat); end
        repeat (3) @(negedge clk);
        check_copy("abort_fresh", 32'h6000, 32'h9000, 3);
    endtask

    task automatic test_wrap();
        int lat; logic b1;
        do_copy(32'hFFFF_FFF0, 32'hA000, 32'd32, 0, lat, b1);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL wrap_latency: got %0d, expected 5", lat); end
        repeat (2) @(negedge clk);
`ifdef MEM_COPY_PERF_EN
        checks++;
        if (perf_cycles !== 32'd5) begin
            errors++;
            $display("FAIL wrap_perf_cycles: got %0d, expected 5", perf_cycles);
        end
`endif
        repeat (2) @(negedge clk);
        check_copy("wrap", 32'hFFFF_FFF0, 32'hA000, 2);
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_pending: got %0d/%0d, expected 0/0", rd_q.size(), wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tail();
        test_zero_len();
        test_restart_ignored();
        test_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
